// File: rtl/approx_add_pipe.sv
// Purpose: pipelined unsigned approximate adder with runtime-selectable low-part mode and an exact-sum error monitor.
// Latency: 2 cycles from the accepting edge to out_valid; one result per cycle when not stalled.
// Backpressure: both stages hold while out_valid & ~out_ready; in_ready = ~out_valid | out_ready.
module approx_add_pipe #(
    parameter int WIDTH       = 8,
    parameter int APPROX_BITS = 4,
    parameter int ERR_CNT_W   = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic [1:0]           in_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH:0]       out_sum,
    output logic [WIDTH:0]       out_err,
    input  logic                 stat_clear,
    output logic [ERR_CNT_W-1:0] stat_count,
    output logic [ERR_CNT_W-1:0] stat_err_sum,
    output logic [WIDTH:0]       stat_err_max
);

    // All arithmetic is done at sum width (WIDTH+1) so that K=0 and K=WIDTH
    // need no zero-width slices: the split between the approximated low part
    // and the exact upper part is expressed purely with masks.
    localparam int SW = WIDTH + 1;
    localparam logic [SW-1:0] ONES_SW   = '1;
    localparam logic [SW-1:0] ONE_SW    = {{WIDTH{1'b0}}, 1'b1};
    // Low K bits set (all zero when K=0).
    localparam logic [SW-1:0] LO_MASK   = ONES_SW >> (SW - APPROX_BITS);
    // Only bit K-1 set (zero when K=0, so the speculative carry is 0 there).
    localparam logic [SW-1:0] TOP_MASK  = LO_MASK ^ (LO_MASK >> 1);
    // Weight of the carry into the upper part (bit K).
    localparam logic [SW-1:0] CARRY_ONE = ONE_SW << APPROX_BITS;
    localparam logic [ERR_CNT_W-1:0] ONE_CNT = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        MODE_EXACT = 2'd0,
        MODE_OR    = 2'd1,
        MODE_TRUNC = 2'd2,
        MODE_SPEC  = 2'd3
    } mode_t;

    // Stage-1 payload: operands for the exact reference, the mode, and the
    // partial results from which stage 2 picks the approximate sum.
    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        mode_t            mode;
        logic [SW-1:0]    lo_add;  // L_a + L_b including its carry-out at bit K
        logic [SW-1:0]    lo_or;   // L_a | L_b
        logic [SW-1:0]    upper;   // U_a + U_b, kept at bit position K and up
        logic             c_spec;  // a[K-1] & b[K-1]
    } s1_t;

    s1_t             s1_d;
    s1_t             s1_q;
    logic            s1_vld;
    logic            adv;
    logic            out_hs;

    logic [SW-1:0]   a_ext;
    logic [SW-1:0]   b_ext;
    logic [SW-1:0]   low_sel;
    logic            c_sel;
    logic [SW-1:0]   approx;
    logic [SW-1:0]   exact;
    logic [SW-1:0]   err;

    logic [ERR_CNT_W-1:0] err_ext;
    logic [ERR_CNT_W:0]   err_sum_wide;
    logic                 count_full;

    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;
    assign out_hs   = out_valid & out_ready;

    // Stage-1 next value: split operands into low/upper parts and form the partial sums.
    always_comb begin
        s1_d        = '0;
        a_ext       = {1'b0, in_a};
        b_ext       = {1'b0, in_b};
        s1_d.a      = in_a;
        s1_d.b      = in_b;
        s1_d.mode   = mode_t'(in_mode);
        s1_d.lo_add = (a_ext & LO_MASK) + (b_ext & LO_MASK);
        s1_d.lo_or  = (a_ext | b_ext) & LO_MASK;
        s1_d.upper  = (a_ext & ~LO_MASK) + (b_ext & ~LO_MASK);
        s1_d.c_spec = |(a_ext & b_ext & TOP_MASK);
    end

    // Stage-1 register: bubbles advance with adv, payload only captured on a real transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld <= 1'b0;
            s1_q   <= '0;
        end else if (adv) begin
            s1_vld <= in_valid;
            if (in_valid) begin
                s1_q <= s1_d;
            end
        end
    end

    // Stage-2 datapath: choose low part and carry by the captured mode, then compare with the exact sum.
    always_comb begin
        low_sel = '0;
        c_sel   = 1'b0;
        case (s1_q.mode)
            MODE_EXACT: begin
                low_sel = s1_q.lo_add & LO_MASK;
                c_sel   = |(s1_q.lo_add & CARRY_ONE);
            end
            MODE_OR: begin
                low_sel = s1_q.lo_or;
                c_sel   = s1_q.c_spec;
            end
            MODE_TRUNC: begin
                low_sel = '0;
                c_sel   = 1'b0;
            end
            MODE_SPEC: begin
                low_sel = s1_q.lo_add & LO_MASK;
                c_sel   = s1_q.c_spec;
            end
        endcase
        approx = s1_q.upper + low_sel + (c_sel ? CARRY_ONE : '0);
        exact  = {1'b0, s1_q.a} + {1'b0, s1_q.b};
        err    = (exact >= approx) ? (exact - approx) : (approx - exact);
    end

    // Stage-2 register: result is only replaced when a new one moves up, so it is stable under stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_err   <= '0;
        end else if (adv) begin
            out_valid <= s1_vld;
            if (s1_vld) begin
                out_sum <= approx;
                out_err <= err;
            end
        end
    end

    // Saturating accumulate helpers for the statistics.
    always_comb begin
        err_ext      = {{(ERR_CNT_W-SW){1'b0}}, out_err};
        err_sum_wide = {1'b0, stat_err_sum} + {1'b0, err_ext};
        count_full   = (stat_count == '1);
    end

    // Statistics: update on output handshake; a clear that coincides with a handshake keeps that result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_count   <= '0;
            stat_err_sum <= '0;
            stat_err_max <= '0;
        end else if (stat_clear) begin
            stat_count   <= out_hs ? ONE_CNT : '0;
            stat_err_sum <= out_hs ? err_ext : '0;
            stat_err_max <= out_hs ? out_err : '0;
        end else if (out_hs) begin
            if (!count_full) begin
                stat_count <= stat_count + ONE_CNT;
            end
            stat_err_sum <= err_sum_wide[ERR_CNT_W] ? '1 : err_sum_wide[ERR_CNT_W-1:0];
            if (out_err > stat_err_max) begin
                stat_err_max <= out_err;
            end
        end
    end

endmodule

// File: tb/tb_approx_add_pipe.sv
// Purpose: self-checking bench for approx_add_pipe (main config plus saturation and K corner configs).
// Latency: expects results two edges after the accepting edge when unstalled.
// Backpressure: exercises stalls via out_ready and checks hold, order and release behaviour.
module tb_approx_add_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic [1:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [8:0]  out_sum;
    logic [8:0]  out_err;
    logic        stat_clear;
    logic [23:0] stat_count;
    logic [23:0] stat_err_sum;
    logic [8:0]  stat_err_max;

    logic        one;
    logic        zero;

    logic        sat_valid, sat_in_ready, sat_out_valid;
    logic [8:0]  sat_sum, sat_err, sat_count, sat_esum, sat_emax;

    logic        k0_valid, k0_in_ready, k0_out_valid;
    logic [8:0]  k0_sum, k0_err, k0_emax;
    logic [23:0] k0_count, k0_esum;

    logic        k8_valid, k8_in_ready, k8_out_valid;
    logic [8:0]  k8_sum, k8_err, k8_emax;
    logic [23:0] k8_count, k8_esum;

    int checks = 0;
    int errors = 0;

    approx_add_pipe #(.WIDTH(8), .APPROX_BITS(4), .ERR_CNT_W(24)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_err(out_err),
        .stat_clear(stat_clear), .stat_count(stat_count), .stat_err_sum(stat_err_sum),
        .stat_err_max(stat_err_max)
    );

    approx_add_pipe #(.WIDTH(8), .APPROX_BITS(4), .ERR_CNT_W(9)) u_sat (
        .clk(clk), .rst(rst), .in_valid(sat_valid), .in_ready(sat_in_ready),
        .in_a(in_a), .in_b(in_b), .in_mode(in_mode),
        .out_valid(sat_out_valid), .out_ready(one), .out_sum(sat_sum), .out_err(sat_err),
        .stat_clear(zero), .stat_count(sat_count), .stat_err_sum(sat_esum),
        .stat_err_max(sat_emax)
    );

    approx_add_pipe #(.WIDTH(8), .APPROX_BITS(0), .ERR_CNT_W(24)) u_k0 (
        .clk(clk), .rst(rst), .in_valid(k0_valid), .in_ready(k0_in_ready),
        .in_a(in_a), .in_b(in_b), .in_mode(in_mode),
        .out_valid(k0_out_valid), .out_ready(one), .out_sum(k0_sum), .out_err(k0_err),
        .stat_clear(zero), .stat_count(k0_count), .stat_err_sum(k0_esum),
        .stat_err_max(k0_emax)
    );

    approx_add_pipe #(.WIDTH(8), .APPROX_BITS(8), .ERR_CNT_W(24)) u_k8 (
        .clk(clk), .rst(rst), .in_valid(k8_valid), .in_ready(k8_in_ready),
        .in_a(in_a), .in_b(in_b), .in_mode(in_mode),
        .out_valid(k8_out_valid), .out_ready(one), .out_sum(k8_sum), .out_err(k8_err),
        .stat_clear(zero), .stat_count(k8_count), .stat_err_sum(k8_esum),
        .stat_err_max(k8_emax)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    // Reference model straight from the mode rules, using integer arithmetic on a 2^K split.
    function automatic int model_sum(input int a, input int b, input int mode, input int k);
        int p, la, lb, low, c, cs;
        p   = 1 << k;
        la  = a % p;
        lb  = b % p;
        cs  = 0;
        if (k > 0) cs = ((a >> (k - 1)) & (b >> (k - 1))) & 1;
        low = 0;
        c   = 0;
        case (mode)
            0: begin low = (la + lb) % p; c = (la + lb) / p; end
            1: begin low = la | lb;       c = cs;            end
            2: begin low = 0;             c = 0;             end
            default: begin low = (la + lb) % p; c = cs;      end
        endcase
        return (a / p + b / p + c) * p + low;
    endfunction

    function automatic int model_err(input int a, input int b, input int mode, input int k);
        int s;
        s = model_sum(a, b, mode, k);
        return (a + b >= s) ? (a + b - s) : (s - a - b);
    endfunction

    // Scoreboard for the main DUT: expected results in acceptance order plus model statistics.
    typedef struct {
        int sum;
        int err;
    } exp_t;

    exp_t   exp_q[$];
    longint m_count = 0;
    longint m_esum  = 0;
    longint m_emax  = 0;
    localparam longint MAXC = (64'd1 << 24) - 1;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                m_count = 0;
                m_esum  = 0;
                m_emax  = 0;
            end
            check("mon_stat_count", stat_count, m_count);
            check("mon_stat_err_sum", stat_err_sum, m_esum);
            check("mon_stat_err_max", stat_err_max, m_emax);
            check("mon_in_ready", in_ready, (!out_valid || out_ready));
            if (rst) begin
                check("mon_valid_in_reset", out_valid, 0);
            end else begin
                bit hs;
                int e;
                hs = 0;
                e  = 0;
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        check("mon_unexpected_result", 1, 0);
                    end else begin
                        check("mon_out_sum", out_sum, exp_q[0].sum);
                        check("mon_out_err", out_err, exp_q[0].err);
                        if (out_ready) begin
                            hs = 1;
                            e  = exp_q[0].err;
                            void'(exp_q.pop_front());
                        end
                    end
                end
                if (stat_clear) begin
                    m_count = hs ? 1 : 0;
                    m_esum  = hs ? e : 0;
                    m_emax  = hs ? e : 0;
                end else if (hs) begin
                    if (m_count < MAXC) m_count++;
                    m_esum = (m_esum + e > MAXC) ? MAXC : m_esum + e;
                    if (e > m_emax) m_emax = e;
                end
                if (in_valid && in_ready) begin
                    exp_t x;
                    x.sum = model_sum(int'(in_a), int'(in_b), int'(in_mode), 4);
                    x.err = model_err(int'(in_a), int'(in_b), int'(in_mode), 4);
                    exp_q.push_back(x);
                end
            end
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [1:0] m);
        bit ok;
        in_a     = a;
        in_b     = b;
        in_mode  = m;
        in_valid = 1'b1;
        ok       = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            ok = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("send_accepted", ok, 1);
    endtask

    // One transaction with literal expectations; returns with the result valid and its handshake pending.
    task automatic single(input logic [7:0] a, input logic [7:0] b, input logic [1:0] m,
                          input int exp_sum, input int exp_err, input string nm);
        int n;
        send(a, b, m);
        n = 1;
        while (!out_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check({nm, "_latency"}, n, 2);
        check({nm, "_sum"}, out_sum, exp_sum);
        check({nm, "_err"}, out_err, exp_err);
    endtask

    typedef struct {
        int a;
        int b;
        int mode;
        int sum;
        int err;
    } vec_t;

    initial begin
        vec_t k8_tab[3];
        logic [8:0] prev;

        k8_tab[0] = '{a: 'h80, b: 'h80, mode: 1, sum: 'h180, err: 128};
        k8_tab[1] = '{a: 'h80, b: 'h80, mode: 2, sum: 'h000, err: 256};
        k8_tab[2] = '{a: 'h80, b: 'h80, mode: 3, sum: 'h100, err: 0};

        one        = 1'b1;
        zero       = 1'b0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_a       = '0;
        in_b       = '0;
        in_mode    = '0;
        out_ready  = 1'b0;
        stat_clear = 1'b0;
        sat_valid  = 1'b0;
        k0_valid   = 1'b0;
        k8_valid   = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sum", out_sum, 0);
        check("rst_out_err", out_err, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_stat_count", stat_count, 0);
        check("rst_stat_err_sum", stat_err_sum, 0);
        check("rst_stat_err_max", stat_err_max, 0);
        rst       = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;

        // Modes and statistics
        single(8'hFF, 8'h01, 2'd0, 'h100, 0,  "mode0");
        single(8'h0F, 8'h01, 2'd1, 'h00F, 1,  "mode1");
        single(8'hFF, 8'hFF, 2'd2, 'h1E0, 30, "mode2");
        single(8'h0F, 8'h01, 2'd3, 'h000, 16, "mode3");
        @(posedge clk); #1;
        check("stats_count", stat_count, 4);
        check("stats_err_sum", stat_err_sum, 47);
        check("stats_err_max", stat_err_max, 30);
        single(8'h08, 8'h08, 2'd3, 'h010, 0, "mode3_carry");
        @(posedge clk); #1;
        single(8'h0F, 8'h01, 2'd3, 'h000, 16, "clear_vec");
        stat_clear = 1'b1;
        @(posedge clk); #1;
        stat_clear = 1'b0;
        check("clear_hs_count", stat_count, 1);
        check("clear_hs_err_sum", stat_err_sum, 16);
        check("clear_hs_err_max", stat_err_max, 16);

        // Backpressure
        out_ready = 1'b0;
        in_a = 8'd1; in_b = 8'd1; in_mode = 2'd0; in_valid = 1'b1;
        check("bp_ready_0", in_ready, 1);
        @(posedge clk); #1;
        in_a = 8'd2;
        check("bp_ready_1", in_ready, 1);
        @(posedge clk); #1;
        in_a = 8'd3;
        check("bp_ready_2", in_ready, 0);
        check("bp_hold_sum", out_sum, 'h002);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("bp_stall_ready", in_ready, 0);
            check("bp_stall_sum", out_sum, 'h002);
            check("bp_stall_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_out2_valid", out_valid, 1);
        check("bp_out2_sum", out_sum, 'h003);
        @(posedge clk); #1;
        check("bp_out3_valid", out_valid, 1);
        check("bp_out3_sum", out_sum, 'h004);
        @(posedge clk); #1;
        check("bp_drained", out_valid, 0);

        // Reset with two results in flight
        out_ready = 1'b0;
        in_a = 8'h10; in_b = 8'h20; in_mode = 2'd0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_a = 8'h30;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("mid_rst_pre_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_count", stat_count, 0);
        check("mid_rst_err_sum", stat_err_sum, 0);
        check("mid_rst_err_max", stat_err_max, 0);
        repeat (2) @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("mid_rst_no_stale", out_valid, 0);
        end

        // Saturation of the error accumulator (ERR_CNT_W=9)
        in_a = 8'hFF; in_b = 8'hFF; in_mode = 2'd2;
        prev = sat_esum;
        sat_valid = 1'b1;
        for (int i = 0; i < 24; i++) begin
            @(posedge clk); #1;
            if (i == 19) sat_valid = 1'b0;
            check("sat_no_wrap", (sat_esum >= prev), 1);
            prev = sat_esum;
        end
        check("sat_count", sat_count, 20);
        check("sat_err_sum", sat_esum, 511);
        check("sat_err_max", sat_emax, 30);

        // K = 0: every mode is exact
        for (int m = 0; m < 4; m++) begin
            in_a = 8'hAB; in_b = 8'h77; in_mode = 2'(m);
            k0_valid = 1'b1;
            @(posedge clk); #1;
            k0_valid = 1'b0;
            @(posedge clk); #1;
            check("k0_valid", k0_out_valid, 1);
            check("k0_sum", k0_sum, 'h122);
            check("k0_err", k0_err, 0);
            check("k0_model", k0_sum, model_sum('hAB, 'h77, m, 0));
        end

        // K = WIDTH: no upper part, carry lands in out_sum[8]
        for (int i = 0; i < 3; i++) begin
            in_a = 8'(k8_tab[i].a); in_b = 8'(k8_tab[i].b); in_mode = 2'(k8_tab[i].mode);
            k8_valid = 1'b1;
            @(posedge clk); #1;
            k8_valid = 1'b0;
            @(posedge clk); #1;
            check("k8_valid", k8_out_valid, 1);
            check("k8_sum", k8_sum, k8_tab[i].sum);
            check("k8_err", k8_err, k8_tab[i].err);
            check("k8_model", k8_sum, model_sum(k8_tab[i].a, k8_tab[i].b, k8_tab[i].mode, 8));
        end

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog timeout");
    end

endmodule

// File: doc/approx_add_pipe.md
Name: approx_add_pipe

Overview:
- Parametrised, pipelined unsigned approximate adder. It is the configurable successor of the fixed 8-bit approximate adders in the adder library.
- The lower APPROX_BITS of the sum come from one of four runtime-selectable approximation modes. The upper part is always exact.
- The block sits in the characterisation datapath and adds two things:
  - a valid/ready stream interface with backpressure;
  - an on-line error monitor: it computes the exact sum in parallel and accumulates transaction count, total absolute error and worst-case error, for in-silicon MAE/WCE measurement.

Parameters:
- WIDTH, 8: operand width in bits, 2..32.
- APPROX_BITS, 4: number of approximated LSBs, 0..WIDTH.
- ERR_CNT_W, 24: width of the statistics counters, at least WIDTH+1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands this cycle.
- in_a  in  WIDTH  operand A, unsigned.
- in_b  in  WIDTH  operand B, unsigned.
- in_mode  in  2  approximation mode, sampled with the operands.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_sum  out  WIDTH+1  approximate sum.
- out_err  out  WIDTH+1  |exact − approximate| for this result.
- stat_clear  in  1  synchronous clear of the statistics.
- stat_count  out  ERR_CNT_W  number of completed output handshakes, saturating.
- stat_err_sum  out  ERR_CNT_W  accumulated absolute error, saturating.
- stat_err_max  out  WIDTH+1  maximum out_err seen since the last clear.

Behaviour:
- Let K = APPROX_BITS, L = a[K-1:0] and b[K-1:0], U = the upper WIDTH−K bits. Result = {U_a + U_b + c, low}, where the carry c and the low part depend on mode:
  - Mode 0, exact: low = (L_a + L_b) mod 2^K; c = true carry out of L. Result equals a+b.
  - Mode 1, lower-part OR: low = L_a | L_b; c = a[K-1] & b[K-1].
  - Mode 2, truncate: low = 0; c = 0.
  - Mode 3, carry speculation: low = (L_a + L_b) mod 2^K; c = a[K-1] & b[K-1].
- Width and corner rules:
  - The upper sum is WIDTH−K+1 bits; its carry-out is out_sum[WIDTH].
  - K=0: all modes are identical to exact; c = 0.
  - K=WIDTH: the upper part is empty and out_sum[WIDTH] = c.
  - The exact sum a+b (WIDTH+1 bits) is computed alongside; out_err = |exact − approx|.
- Pipeline: two register stages, fixed latency 2 cycles from the accept edge to out_valid when not stalled.
  - Stage 1 registers operands, mode, partial low/upper sums and c.
  - Stage 2 registers out_sum, out_err and out_valid.
- Handshake and stall:
  - adv = ~out_valid | out_ready; in_ready = adv. in_ready is combinational from out_ready; no other combinational in-to-out path.
  - Input accepted when in_valid & in_ready. Output consumed when out_valid & out_ready.
  - When adv=0 both stages hold, so at most 2 results are in flight.
  - While stalled, out_sum and out_err must remain stable.
  - Bubbles propagate: the stage-1 valid moves to stage 2 even when 0.
  - Results leave strictly in acceptance order.
- Mode handling: in_mode is captured per transaction. Changing it never affects results already in flight.
- Statistics, updated only on an output handshake:
  - count += 1; err_sum += out_err; err_max = max(err_max, out_err).
  - count and err_sum saturate at 2^ERR_CNT_W − 1.
- stat_clear:
  - Clears all three statistics.
  - If it coincides with an output handshake, the counters load that transaction's values: count=1, err_sum=out_err, err_max=out_err.
- Reset:
  - Values after reset: out_valid=0, stage-1 valid=0, out_sum=0, out_err=0, all statistics 0, in_ready=1 (because out_valid=0).
  - A reset mid-operation discards all in-flight transactions; no handshake completes during reset.

Test Plan (WIDTH=8, APPROX_BITS=4 unless noted):
- Modes, all with out_ready held high:
  - mode 0, a=0xFF, b=0x01: out_sum=0x100, out_err=0.
  - mode 1, a=0x0F, b=0x01: out_sum=0x00F, out_err=1.
  - mode 2, a=0xFF, b=0xFF: out_sum=0x1E0, out_err=30.
  - mode 3, a=0x0F, b=0x01: out_sum=0x000, out_err=16.
  - mode 3, a=0x08, b=0x08: out_sum=0x010, out_err=0.
  - Each result appears exactly 2 cycles after its accept edge.
- Backpressure:
  - Stimulus: out_ready=0; in_valid=1 offering 3 transactions (a=1,2,3 with b=1, mode 0).
  - Required: exactly 2 accepted, then in_ready=0 and out_sum=0x002 held stable.
  - Then out_ready=1: outputs 0x002, 0x003, 0x004 in order on consecutive cycles, and the 3rd input is accepted in the release cycle.
- Statistics:
  - Stimulus: the four single-transaction mode vectors above, in order.
  - Required: stat_count=4, stat_err_sum=47, stat_err_max=30.
  - stat_clear asserted on a mode-3 (a=0x0F, b=0x01) output handshake: count=1, err_sum=16, err_max=16.
- Saturation:
  - Stimulus: ERR_CNT_W=9, WIDTH=8; 20 mode-2 transactions of a=b=0xFF.
  - Required: err_sum saturates at 511 (never wraps); count=20.
- Corners:
  - APPROX_BITS=0, all modes, a=0xAB, b=0x77: out_sum=0x122, out_err=0.
  - APPROX_BITS=8, mode 1, a=0x80, b=0x80: out_sum=0x180.
- Reset mid-flight: assert rst with 2 transactions in flight and out_ready=0. Required: out_valid=0 immediately, statistics 0, no stale result after rst is released.
